// File: rtl/idecode_ctrl.sv
// RV32I decode/control stage: captures each toggled fetch word, drives pcmux/imm back to fetch.
// Latency 1 clk idata->valid; control transfers squash SHADOW shadow words, zero/illegal words halt.
module idecode_ctrl #(
  parameter int unsigned SHADOW       = 1,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] idata,
  input  logic        new_in,
  input  logic [31:0] pc_in,
  output logic [1:0]  pcmux,
  output logic [31:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [3:0]  alu_op,
  output logic        reg_we,
  output logic        mem_re,
  output logic        mem_we,
  output logic [1:0]  wb_sel,
  output logic [31:0] pc_q,
  output logic        valid,
  output logic        illegal,
  output logic        halted
);

  typedef enum logic [1:0] {RUN, SQUASH, HALT} state_e;

  localparam logic [6:0] OP_R = 7'h33, OP_IMM = 7'h13, OP_LOAD = 7'h03, OP_STORE = 7'h23;
  localparam logic [6:0] OP_BR = 7'h63, OP_JAL = 7'h6F, OP_JALR = 7'h67, OP_LUI = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_PASSB = 4'd10;
  localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC = 2'd2, PC_SEQ = 2'd3;
  localparam logic [1:0] SHADOW_CNT = 2'(SHADOW);

  function automatic logic [3:0] alu_sel(input logic [2:0] f, input logic alt);
    case (f)
      3'd0:    alu_sel = alt ? ALU_SUB : ALU_ADD;
      3'd1:    alu_sel = 4'd2;
      3'd2:    alu_sel = 4'd3;
      3'd3:    alu_sel = 4'd4;
      3'd4:    alu_sel = 4'd5;
      3'd5:    alu_sel = alt ? 4'd7 : 4'd6;
      3'd6:    alu_sel = 4'd8;
      default: alu_sel = 4'd9;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        new_q;
  logic        tog;
  logic [1:0]  pcmux_q, pcmux_d, wb_sel_q, wb_sel_d;
  logic [31:0] imm_q, imm_d, pc_lat_q, pc_lat_d;
  logic [4:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [3:0]  alu_q, alu_d;
  logic        reg_we_q, reg_we_d, mem_re_q, mem_re_d, mem_we_q, mem_we_d;
  logic        valid_q, valid_d, illegal_q, illegal_d, halted_q, halted_d;

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        dec_ok, dec_wr, dec_re, dec_we;
  logic [31:0] dec_imm;
  logic [3:0]  dec_alu;
  logic [1:0]  dec_pcmux, dec_wb;

  assign tog   = new_in ^ new_q;
  assign opc   = idata[6:0];
  assign f3    = idata[14:12];
  assign f7    = idata[31:25];
  assign imm_i = {{20{idata[31]}}, idata[31:20]};
  assign imm_s = {{20{idata[31]}}, idata[31:25], idata[11:7]};
  assign imm_b = {{19{idata[31]}}, idata[31], idata[7], idata[30:25], idata[11:8], 1'b0};
  assign imm_u = {idata[31:12], 12'h000};
  assign imm_j = {{11{idata[31]}}, idata[31], idata[19:12], idata[20], idata[30:21], 1'b0};

  always_comb begin
    dec_ok    = 1'b1;
    dec_imm   = imm_i;
    dec_alu   = ALU_ADD;
    dec_pcmux = PC_SEQ;
    dec_wr    = 1'b0;
    dec_re    = 1'b0;
    dec_we    = 1'b0;
    dec_wb    = WB_ALU;
    case (opc)
      OP_R: begin
        dec_wr  = 1'b1;
        dec_alu = alu_sel(f3, idata[30]);
        dec_ok  = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      end
      OP_IMM: begin
        dec_wr  = 1'b1;
        dec_alu = alu_sel(f3, (f3 == 3'd5) && idata[30]);
        if (f3 == 3'd1)      dec_ok = (f7 == 7'h00);
        else if (f3 == 3'd5) dec_ok = (f7 == 7'h00) || (f7 == 7'h20);
      end
      OP_LOAD: begin
        dec_wr = 1'b1;
        dec_re = 1'b1;
        dec_wb = WB_MEM;
        dec_ok = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
      end
      OP_STORE: begin
        dec_we  = 1'b1;
        dec_imm = imm_s;
        dec_ok  = (f3 <= 3'd2);
      end
      OP_BR: begin
        dec_imm   = imm_b;
        dec_alu   = ALU_SUB;
        dec_pcmux = 2'd2;
        dec_ok    = (f3 != 3'd2) && (f3 != 3'd3);
      end
      OP_JAL: begin
        dec_imm   = imm_j;
        dec_pcmux = 2'd1;
        dec_wr    = 1'b1;
        dec_wb    = WB_PC;
      end
      OP_JALR: begin
        dec_pcmux = 2'd0;
        dec_wr    = 1'b1;
        dec_wb    = WB_PC;
        dec_ok    = (f3 == 3'd0);
      end
      OP_LUI: begin
        dec_imm = imm_u;
        dec_alu = ALU_PASSB;
        dec_wr  = 1'b1;
      end
      OP_AUIPC: begin
        dec_imm = imm_u;
        dec_wr  = 1'b1;
      end
      default: dec_ok = 1'b0;
    endcase
  end

  // Strobes/enables default low and pcmux to sequential; decode fields hold unless a word issues.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pcmux_d   = PC_SEQ;
    valid_d   = 1'b0;
    illegal_d = 1'b0;
    reg_we_d  = 1'b0;
    mem_re_d  = 1'b0;
    mem_we_d  = 1'b0;
    imm_d     = imm_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    funct3_d  = funct3_q;
    alu_d     = alu_q;
    wb_sel_d  = wb_sel_q;
    pc_lat_d  = pc_lat_q;
    case (state_q)
      RUN: begin
        if (tog) begin
          if (HALT_ON_ZERO && idata == 32'h0) begin
            state_d = HALT;
          end else if (!dec_ok) begin
            illegal_d = 1'b1;
            state_d   = HALT;
          end else begin
            valid_d  = 1'b1;
            pcmux_d  = dec_pcmux;
            reg_we_d = dec_wr && (idata[11:7] != 5'd0);
            mem_re_d = dec_re;
            mem_we_d = dec_we;
            imm_d    = dec_imm;
            rs1_d    = idata[19:15];
            rs2_d    = idata[24:20];
            rd_d     = idata[11:7];
            funct3_d = f3;
            alu_d    = dec_alu;
            wb_sel_d = dec_wb;
            pc_lat_d = pc_in;
            if (dec_pcmux != PC_SEQ && SHADOW != 0) begin
              state_d = SQUASH;
              cnt_d   = SHADOW_CNT;
            end
          end
        end
      end
      SQUASH: begin
        if (tog) begin
          if (cnt_q <= 2'd1) begin
            cnt_d   = 2'd0;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
      end
      default: ;
    endcase
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk) begin
    new_q <= new_in;
    if (rst) begin
      state_q   <= RUN;
      cnt_q     <= 2'd0;
      pcmux_q   <= PC_SEQ;
      imm_q     <= 32'h0;
      rs1_q     <= 5'd0;
      rs2_q     <= 5'd0;
      rd_q      <= 5'd0;
      funct3_q  <= 3'd0;
      alu_q     <= ALU_ADD;
      wb_sel_q  <= WB_ALU;
      pc_lat_q  <= 32'h0;
      reg_we_q  <= 1'b0;
      mem_re_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pcmux_q   <= pcmux_d;
      imm_q     <= imm_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      funct3_q  <= funct3_d;
      alu_q     <= alu_d;
      wb_sel_q  <= wb_sel_d;
      pc_lat_q  <= pc_lat_d;
      reg_we_q  <= reg_we_d;
      mem_re_q  <= mem_re_d;
      mem_we_q  <= mem_we_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      halted_q  <= halted_d;
    end
  end

  assign pcmux   = pcmux_q;
  assign imm     = imm_q;
  assign rs1     = rs1_q;
  assign rs2     = rs2_q;
  assign rd      = rd_q;
  assign funct3  = funct3_q;
  assign alu_op  = alu_q;
  assign reg_we  = reg_we_q;
  assign mem_re  = mem_re_q;
  assign mem_we  = mem_we_q;
  assign wb_sel  = wb_sel_q;
  assign pc_q    = pc_lat_q;
  assign valid   = valid_q;
  assign illegal = illegal_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_idecode_ctrl.sv
// Bench for idecode_ctrl: instruction-level reference model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_idecode_ctrl;

  localparam int SHADOW = 1;
  localparam int ALU_TAB [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

  logic        clk = 1'b0;
  logic        rst, new_in;
  logic [31:0] idata, pc_in, pc_next;
  logic [1:0]  pcmux, wb_sel;
  logic [31:0] imm, pc_q;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic [3:0]  alu_op;
  logic        reg_we, mem_re, mem_we, valid, illegal, halted;

  int n_chk  = 0;
  int n_pass = 0;

  idecode_ctrl #(.SHADOW(SHADOW), .HALT_ON_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst), .idata(idata), .new_in(new_in), .pc_in(pc_in),
    .pcmux(pcmux), .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd), .funct3(funct3),
    .alu_op(alu_op), .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we),
    .wb_sel(wb_sel), .pc_q(pc_q), .valid(valid), .illegal(illegal), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Instruction-level reference: format/legality by opcode, immediates by signed arithmetic.
  function automatic void mdec(input logic [31:0] w, output bit ok, output logic [31:0] im,
                               output logic [3:0] al, output logic [1:0] pm, output bit wr,
                               output bit re, output bit we, output logic [1:0] wb);
    int sw, op, f3, f7;
    sw = $signed(w);
    op = int'(w[6:0]);
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    ok = 1; im = 32'(sw >>> 20); al = 4'd0; pm = 2'd3; wr = 0; re = 0; we = 0; wb = 2'd0;
    case (op)
      'h33: begin
        wr = 1;
        ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
        al = 4'(ALU_TAB[f3] + ((f7 == 32) ? 1 : 0));
      end
      'h13: begin
        wr = 1;
        al = 4'(ALU_TAB[f3] + ((f3 == 5 && f7 == 32) ? 1 : 0));
        if (f3 == 1) ok = (f7 == 0);
        else if (f3 == 5) ok = (f7 == 0 || f7 == 32);
      end
      'h03: begin wr = 1; re = 1; wb = 2'd1; ok = (f3 inside {0, 1, 2, 4, 5}); end
      'h23: begin
        we = 1; ok = (f3 <= 2);
        im = 32'((sw >>> 25) * 32 + ((sw >>> 7) & 31));
      end
      'h63: begin
        pm = 2'd2; al = 4'd1; ok = !(f3 inside {2, 3});
        im = 32'((sw >>> 31) * 4096 + ((sw >>> 7) & 1) * 2048 + ((sw >>> 25) & 63) * 32
                 + ((sw >>> 8) & 15) * 2);
      end
      'h6F: begin
        wr = 1; pm = 2'd1; wb = 2'd2;
        im = 32'((sw >>> 31) * 1048576 + ((sw >>> 12) & 255) * 4096 + ((sw >>> 20) & 1) * 2048
                 + ((sw >>> 21) & 1023) * 2);
      end
      'h67: begin wr = 1; pm = 2'd0; wb = 2'd2; ok = (f3 == 0); end
      'h37: begin wr = 1; al = 4'd10; im = w & 32'hFFFFF000; end
      'h17: begin wr = 1; im = w & 32'hFFFFF000; end
      default: ok = 0;
    endcase
    if (w[11:7] == 5'd0) wr = 0;
  endfunction

  // Model state: mode 0 run, 1 squashing, 2 halted.
  bit          live = 0;
  logic        m_prev;
  int          m_mode, m_left;
  bit          e_known, e_valid, e_ill, e_halt, e_rwe, e_mre, e_mwe;
  logic [1:0]  e_pcmux, e_wb;
  logic [31:0] e_imm, e_pc;
  logic [4:0]  e_rs1, e_rs2, e_rd;
  logic [2:0]  e_f3;
  logic [3:0]  e_alu;

  always @(posedge clk) begin : model
    bit ok, wr, re, we, tg;
    logic [31:0] im;
    logic [3:0] al;
    logic [1:0] pm, wb;
    int nm, nl;
    if (rst) begin
      live <= 1; m_prev <= new_in; m_mode <= 0; m_left <= 0; e_known <= 1;
      e_valid <= 0; e_ill <= 0; e_halt <= 0; e_rwe <= 0; e_mre <= 0; e_mwe <= 0;
      e_pcmux <= 2'd3; e_wb <= 2'd0; e_imm <= 32'h0; e_pc <= 32'h0;
      e_rs1 <= 5'd0; e_rs2 <= 5'd0; e_rd <= 5'd0; e_f3 <= 3'd0; e_alu <= 4'd0;
    end else begin
      tg = (new_in != m_prev);
      m_prev <= new_in;
      nm = m_mode; nl = m_left;
      e_valid <= 0; e_ill <= 0; e_pcmux <= 2'd3; e_rwe <= 0; e_mre <= 0; e_mwe <= 0;
      if (tg && m_mode == 0) begin
        mdec(idata, ok, im, al, pm, wr, re, we, wb);
        if (idata == 32'h0) begin
          nm = 2; e_known <= 0;
        end else if (!ok) begin
          nm = 2; e_ill <= 1; e_known <= 0;
        end else begin
          e_valid <= 1; e_pcmux <= pm; e_rwe <= wr; e_mre <= re; e_mwe <= we;
          e_imm <= im; e_alu <= al; e_wb <= wb; e_pc <= pc_in; e_known <= 1;
          e_rs1 <= idata[19:15]; e_rs2 <= idata[24:20]; e_rd <= idata[11:7];
          e_f3 <= idata[14:12];
          if (pm != 2'd3 && SHADOW > 0) begin nm = 1; nl = SHADOW; end
        end
      end else if (tg && m_mode == 1) begin
        nl = nl - 1;
        if (nl <= 0) begin nm = 0; nl = 0; end
      end
      m_mode <= nm; m_left <= nl; e_halt <= (nm == 2);
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("valid", 32'(valid), 32'(e_valid));
      chk("illegal", 32'(illegal), 32'(e_ill));
      chk("halted", 32'(halted), 32'(e_halt));
      chk("pcmux", 32'(pcmux), 32'(e_pcmux));
      chk("reg_we", 32'(reg_we), 32'(e_rwe));
      chk("mem_re", 32'(mem_re), 32'(e_mre));
      chk("mem_we", 32'(mem_we), 32'(e_mwe));
      if (e_known) begin
        chk("imm", imm, e_imm);
        chk("rs1", 32'(rs1), 32'(e_rs1));
        chk("rs2", 32'(rs2), 32'(e_rs2));
        chk("rd", 32'(rd), 32'(e_rd));
        chk("funct3", 32'(funct3), 32'(e_f3));
        chk("alu_op", 32'(alu_op), 32'(e_alu));
        chk("wb_sel", 32'(wb_sel), 32'(e_wb));
        chk("pc_q", pc_q, e_pc);
      end
    end
  end

  // Called at a negedge; presents a word with a toggle and returns at the next negedge.
  task automatic fetch(input logic [31:0] w);
    idata = w;
    pc_in = pc_next;
    pc_next = pc_next + 32'd4;
    new_in = ~new_in;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; new_in = 1'b0; idata = 32'h0; pc_in = 32'h0; pc_next = 32'h100;
    repeat (3) @(negedge clk);
    chk("rst pcmux", 32'(pcmux), 32'd3);
    chk("rst valid", 32'(valid), 32'd0);
    chk("rst imm", imm, 32'd0);
    chk("rst halted", 32'(halted), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // T1 addi x1,x0,5
    fetch(32'h00500093);
    chk("T1 valid", 32'(valid), 32'd1);
    chk("T1 rd", 32'(rd), 32'd1);
    chk("T1 imm", imm, 32'd5);
    chk("T1 alu_op", 32'(alu_op), 32'd0);
    chk("T1 reg_we", 32'(reg_we), 32'd1);
    chk("T1 pcmux", 32'(pcmux), 32'd3);
    @(negedge clk);
    chk("T1 idle valid", 32'(valid), 32'd0);

    // T2 jal x1,+8 then squashed shadow, then a live addi x2,x0,10
    fetch(32'h008000EF);
    chk("T2 pcmux", 32'(pcmux), 32'd1);
    chk("T2 imm", imm, 32'd8);
    chk("T2 wb_sel", 32'(wb_sel), 32'd2);
    fetch(32'h00500093);
    chk("T2 shadow valid", 32'(valid), 32'd0);
    chk("T2 shadow pcmux", 32'(pcmux), 32'd3);
    fetch(32'h00A00113);
    chk("T2 next valid", 32'(valid), 32'd1);
    chk("T2 next rd", 32'(rd), 32'd2);

    // T3 beq with negative offset
    fetch(32'hFE000EE3);
    chk("T3 pcmux", 32'(pcmux), 32'd2);
    chk("T3 imm", imm, 32'hFFFFFFFC);
    chk("T3 reg_we", 32'(reg_we), 32'd0);
    fetch(32'h00500093);
    chk("T3 shadow valid", 32'(valid), 32'd0);

    // T4 sw x2,-4(x1); lw x3,0(x1)
    fetch(32'hFE20AE23);
    chk("T4 mem_we", 32'(mem_we), 32'd1);
    chk("T4 imm", imm, 32'hFFFFFFFC);
    chk("T4 reg_we", 32'(reg_we), 32'd0);
    fetch(32'h0000A183);
    chk("T4 mem_re", 32'(mem_re), 32'd1);
    chk("T4 wb_sel", 32'(wb_sel), 32'd1);

    // More decode patterns: sub, srai, lui, jalr (+shadow), addi to x0
    fetch(32'h407302B3);
    chk("sub alu_op", 32'(alu_op), 32'd1);
    fetch(32'h4030D093);
    chk("srai alu_op", 32'(alu_op), 32'd7);
    fetch(32'h12345237);
    chk("lui imm", imm, 32'h12345000);
    chk("lui alu_op", 32'(alu_op), 32'd10);
    fetch(32'h000280E7);
    chk("jalr pcmux", 32'(pcmux), 32'd0);
    fetch(32'h00500093);
    fetch(32'h00100013);
    chk("x0 valid", 32'(valid), 32'd1);
    chk("x0 reg_we", 32'(reg_we), 32'd0);

    // T5 zero word halts; later toggles ignored
    fetch(32'h00000000);
    chk("T5 halted", 32'(halted), 32'd1);
    chk("T5 illegal", 32'(illegal), 32'd0);
    fetch(32'h00500093);
    chk("T5 after valid", 32'(valid), 32'd0);
    do_reset();
    @(negedge clk);
    fetch(32'h0000007F);
    chk("T5 illegal pulse", 32'(illegal), 32'd1);
    chk("T5 illegal valid", 32'(valid), 32'd0);
    @(negedge clk);
    chk("T5 illegal drop", 32'(illegal), 32'd0);
    chk("T5 illegal halted", 32'(halted), 32'd1);
    do_reset();
    fetch(32'h40109093);
    chk("bad slli illegal", 32'(illegal), 32'd1);

    // T6 reset mid-squash with a toggle in the same cycle
    do_reset();
    fetch(32'h008000EF);
    rst = 1'b1;
    idata = 32'h00500093;
    new_in = ~new_in;
    @(negedge clk);
    chk("T6 valid", 32'(valid), 32'd0);
    chk("T6 pcmux", 32'(pcmux), 32'd3);
    chk("T6 imm", imm, 32'd0);
    chk("T6 wb_sel", 32'(wb_sel), 32'd0);
    chk("T6 pc_q", pc_q, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("T6 post valid", 32'(valid), 32'd0);
    fetch(32'h00500093);
    chk("T6 resume valid", 32'(valid), 32'd1);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
